// File: rtl/wide_add_seq.sv
// Multi-word adder sequencer: streams 32-bit slices LSB-first through an external
// registered ripple-carry adder (2-edge latency) and assembles the full-width sum.
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [32*WORDS-1:0]   a_in,
    input  logic [32*WORDS-1:0]   b_in,
    input  logic                  ci_in,
    output logic                  busy,
    output logic                  done,
    output logic [32*WORDS-1:0]   sum,
    output logic                  co_out,
    output logic [31:0]           add_a,
    output logic [31:0]           add_b,
    output logic                  add_ci,
    input  logic [31:0]           add_s,
    input  logic                  add_co
);

    // state     | meaning
    // S_IDLE    | waiting for start, operands latched on accept
    // S_ISSUE   | slice 0 driven into the adder
    // S_WAIT    | adder moving slice from input to output register
    // S_COLLECT | adder output holds slice idx; next slice issued unless last

    localparam int W  = 32 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_COLLECT
    } state_t;

    state_t          state, state_nxt;
    logic [W-1:0]    a_l, b_l, shadow, shadow_merged;
    logic            ci_l;
    logic [IW-1:0]   idx, idx_p1;
    logic            accept, collect, last;

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        add_a         = '0;
        add_b         = '0;
        add_ci        = 1'b0;
        accept        = 1'b0;
        collect       = 1'b0;
        last          = (idx == LAST);
        idx_p1        = idx + 1'b1;
        shadow_merged = shadow;
        shadow_merged[32*idx +: 32] = add_s;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                add_a     = a_l[31:0];
                add_b     = b_l[31:0];
                add_ci    = ci_l;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                state_nxt = S_COLLECT;
            end
            S_COLLECT: begin
                collect = 1'b1;
                if (!last) begin
                    // carry chains straight from the adder's registered co
                    add_a     = a_l[32*idx_p1 +: 32];
                    add_b     = b_l[32*idx_p1 +: 32];
                    add_ci    = add_co;
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_l    <= '0;
            b_l    <= '0;
            ci_l   <= 1'b0;
            idx    <= '0;
            shadow <= '0;
            sum    <= '0;
            co_out <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= collect && last;
            if (accept) begin
                a_l  <= a_in;
                b_l  <= b_in;
                ci_l <= ci_in;
                idx  <= '0;
            end
            if (collect) begin
                shadow <= shadow_merged;
                if (last) begin
                    sum    <= shadow_merged;
                    co_out <= add_co;
                end else begin
                    idx <= idx_p1;
                end
            end
        end
    end

endmodule
